// File: rtl/crc5_pkg.sv
// Shared CRC-5 constants and the single-bit serial update used by the parallel engine.
package crc5_pkg;

    localparam int          CRC_W          = 5;
    localparam logic [4:0]  DEFAULT_POLY   = 5'h05;
    localparam int          DEFAULT_DATA_W = 4;

    // One serial CRC step: shift left, fold in the polynomial when the feedback bit is set.
    function automatic logic [CRC_W-1:0] crc5_step_bit(
        input logic [CRC_W-1:0] crc,
        input logic             d,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = crc[CRC_W-1] ^ d;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc5_comb.sv
// Combinational CRC-5 update over DATA_W bits, MSB of data absorbed first.
module crc5_comb
    import crc5_pkg::*;
#(
    parameter int         DATA_W = DEFAULT_DATA_W,
    parameter logic [4:0] POLY   = DEFAULT_POLY
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data,
    output logic [CRC_W-1:0]  crc_out
);

    // chain[DATA_W] is the incoming CRC; each stage below absorbs one more data bit.
    logic [DATA_W:0][CRC_W-1:0] chain;

    assign chain[DATA_W] = crc_in;

    for (genvar i = DATA_W - 1; i >= 0; i--) begin : g_step
        assign chain[i] = crc5_step_bit(chain[i+1], data[i], POLY);
    end

    assign crc_out = chain[0];

endmodule

// File: rtl/crc5_parallel.sv
// Inline parallel CRC-5: one DATA_W-bit word per clock, seeded from crc5_init after reset.
module crc5_parallel
    import crc5_pkg::*;
#(
    parameter int         DATA_W = DEFAULT_DATA_W,
    parameter logic [4:0] POLY   = DEFAULT_POLY,
    parameter int         CRC_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CRC_W-1:0]  crc5_init,
    output logic [CRC_W-1:0]  crc5
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_base;
    logic [CRC_W-1:0] crc_nxt;
    logic             first_q;

    // The seed replaces the register only on the first edge out of reset.
    assign crc_base = first_q ? crc5_init : crc_q;

    crc5_comb #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_comb (
        .crc_in  (crc_base),
        .data    (data_in),
        .crc_out (crc_nxt)
    );

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            crc_q   <= '0;
            first_q <= 1'b1;
        end else begin
            crc_q   <= crc_nxt;
            first_q <= 1'b0;
        end
    end

    assign crc5 = crc_q;

endmodule

// File: tb/tb_crc5_parallel.sv
// Self-checking bench for crc5_parallel against a polynomial-division reference model.
module tb_crc5_parallel;

    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_in;
    logic [4:0]        crc5_init;
    logic [4:0]        crc5;

    int n_checks = 0;
    int n_fail   = 0;

    crc5_parallel #(.DATA_W(DATA_W), .POLY(5'h05), .CRC_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .crc5_init (crc5_init),
        .crc5      (crc5)
    );

    always #5 clk = ~clk;

    // New CRC = (crc * x^DATA_W + data * x^5) mod (x^5 + x^2 + 1), by long division.
    function automatic logic [4:0] ref_f(input logic [4:0] c, input logic [DATA_W-1:0] d);
        logic [15:0] v;
        v = (16'(c) << DATA_W) ^ (16'(d) << 5);
        for (int k = 15; k >= 5; k--)
            if (v[k]) v = v ^ (16'h25 << (k - 5));
        return v[4:0];
    endfunction

    task automatic pulse_reset(input logic [4:0] init, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b0;
        crc5_init = init;
        data_in   = d;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        pulse_reset(5'h13, 4'h9);
        exp = ref_f(5'h13, 4'h9);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (crc5 !== exp) begin
                n_fail++;
                $display("FAIL reset_prerun cyc%0d: got %h want %h", i, crc5, exp);
            end
            data_in = 4'($urandom);
            exp = ref_f(exp, data_in);
        end
        // Assert reset between edges; output must clear without a clock.
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (crc5 !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 00", crc5);
        end
        for (int i = 0; i < 3; i++) begin
            data_in   = 4'($urandom);
            crc5_init = 5'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (crc5 !== 5'h00) begin
                n_fail++;
                $display("FAIL reset_hold edge%0d: got %h want 00", i, crc5);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_h1_columns();
        logic [4:0] tbl [4];
        tbl = '{5'h05, 5'h0A, 5'h14, 5'h0D};
        for (int i = 0; i < 4; i++) begin
            pulse_reset(5'h00, 4'(1 << i));
            @(posedge clk); #1;
            n_checks++;
            if (crc5 !== tbl[i]) begin
                n_fail++;
                $display("FAIL h1_col%0d: got %h want %h", i, crc5, tbl[i]);
            end
        end
    endtask

    task automatic test_h2_columns();
        logic [4:0] tbl [5];
        tbl = '{5'h10, 5'h05, 5'h0A, 5'h14, 5'h0D};
        for (int i = 0; i < 5; i++) begin
            pulse_reset(5'(1 << i), 4'h0);
            @(posedge clk); #1;
            n_checks++;
            if (crc5 !== tbl[i]) begin
                n_fail++;
                $display("FAIL h2_col%0d: got %h want %h", i, crc5, tbl[i]);
            end
        end
    endtask

    task automatic test_accumulate();
        pulse_reset(5'h00, 4'h1);
        @(posedge clk); #1;
        n_checks++;
        if (crc5 !== 5'h05) begin
            n_fail++;
            $display("FAIL accum_edge1: got %h want 05", crc5);
        end
        @(posedge clk); #1;
        n_checks++;
        if (crc5 !== 5'h1F) begin
            n_fail++;
            $display("FAIL accum_edge2: got %h want 1f", crc5);
        end
    endtask

    task automatic test_reseed();
        pulse_reset(5'($urandom), 4'($urandom));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            data_in = 4'($urandom);
        end
        pulse_reset(5'h08, 4'h0);
        @(posedge clk); #1;
        n_checks++;
        if (crc5 !== 5'h14) begin
            n_fail++;
            $display("FAIL reseed: got %h want 14", crc5);
        end
    endtask

    task automatic test_linearity();
        logic [4:0] lin;
        pulse_reset(5'h10, 4'h1);
        @(posedge clk); #1;
        lin = ref_f(5'h10, 4'h0) ^ ref_f(5'h00, 4'h1);
        n_checks++;
        if (crc5 !== 5'h08 || crc5 !== lin) begin
            n_fail++;
            $display("FAIL linearity: got %h want %h", crc5, lin);
        end
    endtask

    task automatic test_random_stream();
        logic [4:0] exp;
        logic [4:0] seed;
        for (int run = 0; run < 4; run++) begin
            seed = 5'($urandom);
            pulse_reset(seed, 4'($urandom));
            exp = ref_f(seed, data_in);
            for (int i = 0; i < 24; i++) begin
                @(posedge clk); #1;
                n_checks++;
                if (crc5 !== exp) begin
                    n_fail++;
                    $display("FAIL random run%0d cyc%0d: got %h want %h", run, i, crc5, exp);
                end
                // Seed changes after the first edge must be ignored.
                crc5_init = 5'($urandom);
                data_in   = 4'($urandom);
                exp = ref_f(exp, data_in);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        data_in   = '0;
        crc5_init = '0;
        #2;
        n_checks++;
        if (crc5 !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_initial: got %h want 00", crc5);
        end
        @(posedge clk); #1;
        n_checks++;
        if (crc5 !== 5'h00) begin
            n_fail++;
            $display("FAIL reset_initial_edge: got %h want 00", crc5);
        end
        test_reset();
        test_h1_columns();
        test_h2_columns();
        test_accumulate();
        test_reseed();
        test_linearity();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
